csr_axil_write_responder: RTL and testbench
===========================================

Name: csr_axil_write_responder

Overview:
- AXI-Lite write slave on the CSR side of the commit stage's CSR write master.
- Accepts the AW and W channels independently and decodes the 12-bit CSR address for legality.
- Issues a single write pulse to the CSR register file and returns a B response held until the master accepts it.
- Sits between the pipeline's CSR write channel and the CSR register file.

Parameters:
- ADDR_W, 12, CSR address width.
- DATA_W, 32, CSR data width.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- axil_csr_awaddr  in  ADDR_W  write address.
- axil_csr_awvalid  in  1  address valid.
- axil_csr_awready  out  1  address accepted.
- axil_csr_wdata  in  DATA_W  write data.
- axil_csr_wvalid  in  1  data valid.
- axil_csr_wready  out  1  data accepted.
- axil_csr_bresp  out  3  response code: 0 OKAY, 2 SLVERR; bit 2 always 0.
- axil_csr_bvalid  out  1  response valid.
- axil_csr_bready  in  1  response accepted.
- csr_wr_addr  out  ADDR_W  register-file write address.
- csr_wr_data  out  DATA_W  register-file write data.
- csr_wr_en  out  1  one-cycle write strobe.
- csr_wr_busy  in  1  register file cannot take a write this cycle.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE, both hold flags 0, buffers 0.
  - Outputs during reset: awready=0, wready=0, bvalid=0, bresp=0, csr_wr_en=0.
  - First cycle after release: awready=1, wready=1.
- Hold flags aw_held and w_held; registers addr_buf and data_buf.
- awready = (state==IDLE) && !aw_held. wready = (state==IDLE) && !w_held.
- AW handshake (awvalid && awready): capture addr_buf, set aw_held. W handshake likewise for data_buf and w_held.
- AW and W may complete in the same cycle, or in either order across cycles. Each channel is accepted once per transaction.
- States:
  - IDLE -> WRITE when both flags are set at the clock edge, whether set previously or by this cycle's handshakes.
  - WRITE: address is legal and csr_wr_busy=0 -> csr_wr_en=1 for one cycle, go to RESP, bresp latched OKAY.
  - WRITE: address is legal and csr_wr_busy=1 -> remain in WRITE with csr_wr_en=0.
  - WRITE: address is illegal -> no write strobe, go to RESP, bresp latched SLVERR. csr_wr_busy is ignored.
  - RESP: bvalid=1 with bresp stable. On bready, clear both flags and go to IDLE.
- csr_wr_addr = addr_buf and csr_wr_data = data_buf at all times. Only csr_wr_en qualifies them.
- Minimum latency: both handshakes in cycle N -> csr_wr_en in N+1 -> bvalid from N+2. awready/wready reassert the cycle after the bready handshake.
- Legal write addresses: 0x300, 0x304, 0x305, 0x340, 0x341, 0x342, 0x343, 0x344.
- Illegal: everything else, including read-only space (addr[11:10]==2'b11) and 0x301 (misa, hardwired).
- While the block is in WRITE or RESP, awvalid/wvalid are not accepted and must be held by the master.
- bvalid never drops without bready.
- Reset asserted mid-transaction: the transaction is abandoned, no strobe is issued, and no response is returned.

Optional Feature:
- CSR_WRITE_ERR_COUNT_EN.
  - Defined: adds output port csr_wr_err_count [15:0]. It increments on each RESP entry with SLVERR, saturates at 0xFFFF, and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams (MSTATUS=0x300, MISA=0x301, MIE=0x304, MTVEC=0x305, MSCRATCH=0x340, MEPC=0x341, MCAUSE=0x342, MTVAL=0x343, MIP=0x344).
  - BRESP codes (OKAY=3'd0, SLVERR=3'd2).
  - The state enum {IDLE, WRITE, RESP}.
- One combinational sub-module, csr_write_decode: addr in, legal out. It is reused later by the read responder.

Test Plan:
- Simultaneous AW(0x340)/W(0xDEADBEEF), bready=1 -> csr_wr_en one cycle after the handshake with addr 0x340, data 0xDEADBEEF; the cycle after that, bvalid=1, bresp=0.
- W(0x12345678) three cycles before AW(0x305) -> wready low after the W handshake, awready still high; one strobe with addr 0x305, data 0x12345678; bresp=0.
- AW(0xF14)/W(0x1) -> no csr_wr_en, bvalid with bresp=2. AW(0x301) also -> bresp=2. With CSR_WRITE_ERR_COUNT_EN, count reads 2.
- csr_wr_busy=1 for 4 cycles during WRITE -> csr_wr_en held low, then exactly one strobe when busy drops, then bvalid.
- bready held low for 5 cycles -> bvalid and bresp stable; awready=wready=0 throughout; both reassert the cycle after bready.
- reset_n pulsed low in RESP -> bvalid drops immediately (async); after release the block is IDLE with awready=wready=1 and no spurious csr_wr_en.

Source files
------------

// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
//   Shared definitions for the machine-mode CSR write path.
//   Contents:
//     - Machine-mode CSR addresses used by the write legality decode.
//     - AXI-Lite B-channel response codes (3-bit field, bit 2 always 0).
//     - Write responder state encoding.
// ---------------------------------------------------------------------------
package csr_pkg;

  localparam logic [11:0] MSTATUS  = 12'h300;
  localparam logic [11:0] MISA     = 12'h301;
  localparam logic [11:0] MIE      = 12'h304;
  localparam logic [11:0] MTVEC    = 12'h305;
  localparam logic [11:0] MSCRATCH = 12'h340;
  localparam logic [11:0] MEPC     = 12'h341;
  localparam logic [11:0] MCAUSE   = 12'h342;
  localparam logic [11:0] MTVAL    = 12'h343;
  localparam logic [11:0] MIP      = 12'h344;

  localparam logic [2:0] OKAY   = 3'd0;
  localparam logic [2:0] SLVERR = 3'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/csr_write_decode.sv
// ---------------------------------------------------------------------------
// csr_write_decode
//   Combinational legality check for CSR write addresses.
//   Ports:
//     addr  in  ADDR_W  CSR address
//     legal out 1       1 when the address names a writable CSR
//   Only the writable machine-mode CSRs decode as legal. MISA is hardwired
//   and everything in the read-only space (addr[11:10]==2'b11) falls out of
//   the exact-match decode as illegal.
// ---------------------------------------------------------------------------
module csr_write_decode
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              legal
);

  always_comb begin
    legal = 1'b0;
    case (addr)
      ADDR_W'(MSTATUS),
      ADDR_W'(MIE),
      ADDR_W'(MTVEC),
      ADDR_W'(MSCRATCH),
      ADDR_W'(MEPC),
      ADDR_W'(MCAUSE),
      ADDR_W'(MTVAL),
      ADDR_W'(MIP):     legal = 1'b1;
      default:          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_axil_write_responder.sv
// ---------------------------------------------------------------------------
// csr_axil_write_responder
//   AXI-Lite write slave that turns one AW+W pair into a single write strobe
//   on the CSR register file and returns a B response.
//
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     axil_csr_aw{addr,valid,ready} write address channel
//     axil_csr_w{data,valid,ready}  write data channel
//     axil_csr_b{resp,valid,ready}  write response channel (OKAY / SLVERR)
//     csr_wr_addr, csr_wr_data     register-file write address / data
//     csr_wr_en                    one-cycle write strobe
//     csr_wr_busy                  register file cannot accept a write
//     csr_wr_err_count             SLVERR response count (optional)
//
//   Build option:
//     CSR_WRITE_ERR_COUNT_EN  adds csr_wr_err_count, a saturating 16-bit
//                             count of SLVERR responses.
// ---------------------------------------------------------------------------
module csr_axil_write_responder
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] axil_csr_awaddr,
  input  logic              axil_csr_awvalid,
  output logic              axil_csr_awready,
  input  logic [DATA_W-1:0] axil_csr_wdata,
  input  logic              axil_csr_wvalid,
  output logic              axil_csr_wready,
  output logic [2:0]        axil_csr_bresp,
  output logic              axil_csr_bvalid,
  input  logic              axil_csr_bready,
  output logic [ADDR_W-1:0] csr_wr_addr,
  output logic [DATA_W-1:0] csr_wr_data,
  output logic              csr_wr_en,
  input  logic              csr_wr_busy
`ifdef CSR_WRITE_ERR_COUNT_EN
  ,
  output logic [15:0]       csr_wr_err_count
`endif
);

  state_t            state_q;
  state_t            state_d;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] addr_buf;
  logic [DATA_W-1:0] data_buf;
  logic [2:0]        bresp_q;

  logic              aw_hs;
  logic              w_hs;
  logic              legal;
  logic              enter_resp;
  logic [2:0]        resp_code;
  logic              wr_en;

  csr_write_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr  (addr_buf),
    .legal (legal)
  );

  // The ready terms are qualified by reset_n so both channels read as not
  // ready while reset is held, not only after the first clock edge.
  assign axil_csr_awready = reset_n && (state_q == IDLE) && !aw_held;
  assign axil_csr_wready  = reset_n && (state_q == IDLE) && !w_held;
  assign aw_hs            = axil_csr_awvalid && axil_csr_awready;
  assign w_hs             = axil_csr_wvalid  && axil_csr_wready;

  assign axil_csr_bvalid  = (state_q == RESP);
  assign axil_csr_bresp   = bresp_q;
  assign csr_wr_addr      = addr_buf;
  assign csr_wr_data      = data_buf;
  assign csr_wr_en        = wr_en;

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    enter_resp = 1'b0;
    resp_code  = OKAY;
    case (state_q)
      IDLE: begin
        // A flag counts as set if it was held already or is being set by
        // this cycle's handshake, so a same-cycle AW+W pair still advances.
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (!legal) begin
          // Illegal writes never touch the register file, so busy is moot.
          enter_resp = 1'b1;
          resp_code  = SLVERR;
          state_d    = RESP;
        end else if (!csr_wr_busy) begin
          wr_en      = 1'b1;
          enter_resp = 1'b1;
          resp_code  = OKAY;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (axil_csr_bready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      addr_buf <= '0;
      data_buf <= '0;
      bresp_q  <= OKAY;
    end else begin
      state_q <= state_d;
      // Handshakes only happen in IDLE and flags only clear in RESP, so the
      // set and clear paths below never collide.
      if (aw_hs) begin
        addr_buf <= axil_csr_awaddr;
        aw_held  <= 1'b1;
      end
      if (w_hs) begin
        data_buf <= axil_csr_wdata;
        w_held   <= 1'b1;
      end
      if ((state_q == RESP) && axil_csr_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (enter_resp) begin
        bresp_q <= resp_code;
      end
    end
  end

`ifdef CSR_WRITE_ERR_COUNT_EN
  logic [15:0] err_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count_q <= '0;
    end else if (enter_resp && (resp_code == SLVERR) && (err_count_q != 16'hFFFF)) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end

  assign csr_wr_err_count = err_count_q;
`endif

endmodule

// File: tb/tb_csr_axil_write_responder.sv
module tb_csr_axil_write_responder;

  logic        clk;
  logic        reset_n;
  logic [11:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [2:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_busy;
`ifdef CSR_WRITE_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [11:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t        wr_q[$];
  logic [2:0] b_q[$];

  csr_axil_write_responder #(
    .ADDR_W (12),
    .DATA_W (32)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .axil_csr_awaddr  (awaddr),
    .axil_csr_awvalid (awvalid),
    .axil_csr_awready (awready),
    .axil_csr_wdata   (wdata),
    .axil_csr_wvalid  (wvalid),
    .axil_csr_wready  (wready),
    .axil_csr_bresp   (bresp),
    .axil_csr_bvalid  (bvalid),
    .axil_csr_bready  (bready),
    .csr_wr_addr      (wr_addr),
    .csr_wr_data      (wr_data),
    .csr_wr_en        (wr_en),
    .csr_wr_busy      (wr_busy)
`ifdef CSR_WRITE_ERR_COUNT_EN
    ,
    .csr_wr_err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT strobes the
  // register file or completes a B handshake.
  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (wr_en) begin
          if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe actual=addr 0x%0h data 0x%0h required=no strobe", wr_addr, wr_data);
          end else begin
            e = wr_q.pop_front();
            chk("strobe_addr", 64'(wr_addr), 64'(e.a));
            chk("strobe_data", 64'(wr_data), 64'(e.d));
          end
        end
        if (bvalid && bready) begin
          if (b_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_bresp actual=%0d required=no response", bresp);
          end else begin
            chk("bresp", 64'(bresp), 64'(b_q.pop_front()));
          end
        end
      end
    end
  endtask

  // Present AW and W together and drop each valid once its handshake lands.
  task automatic send(input logic [11:0] a, input logic [31:0] d);
    int  n;
    logic aw_go;
    logic w_go;
    awaddr  = a;
    wdata   = d;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      @(negedge clk);
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      step();
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      n++;
    end
    chk("send_accepted", 64'(awvalid || wvalid), 64'd0);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic wait_bvalid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", 64'(bvalid), 64'd1);
  endtask

  task automatic wait_b();
    wait_bvalid();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    awaddr   = '0;
    awvalid  = 1'b0;
    wdata    = '0;
    wvalid   = 1'b0;
    bready   = 1'b1;
    wr_busy  = 1'b0;

    fork
      monitor();
    join_none

    // Reset state
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready",  64'(wready),  64'd0);
    chk("rst_bvalid",  64'(bvalid),  64'd0);
    chk("rst_bresp",   64'(bresp),   64'd0);
    chk("rst_wr_en",   64'(wr_en),   64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_wready",  64'(wready),  64'd1);
    step();

    // Illegal addresses: read-only space and hardwired MISA
    b_q.push_back(3'd2);
    send(12'hF14, 32'h1);
    wait_b();
    b_q.push_back(3'd2);
    send(12'h301, 32'h5);
    wait_b();
`ifdef CSR_WRITE_ERR_COUNT_EN
    chk("err_count", 64'(err_count), 64'd2);
`endif

    // Simultaneous AW/W, minimum latency
    wr_q.push_back('{a: 12'h340, d: 32'hDEADBEEF});
    b_q.push_back(3'd0);
    awaddr  = 12'h340;
    wdata   = 32'hDEADBEEF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    chk("t1_awready", 64'(awready), 64'd1);
    chk("t1_wready",  64'(wready),  64'd1);
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge clk);
    chk("t1_wr_en_n1", 64'(wr_en),  64'd1);
    chk("t1_bvalid_n1", 64'(bvalid), 64'd0);
    step();
    @(negedge clk);
    chk("t1_bvalid_n2", 64'(bvalid), 64'd1);
    chk("t1_wr_en_n2",  64'(wr_en),  64'd0);
    step();
    @(negedge clk);
    chk("t1_awready_after", 64'(awready), 64'd1);
    chk("t1_wready_after",  64'(wready),  64'd1);
    chk("t1_bvalid_after",  64'(bvalid),  64'd0);
    step();

    // W three cycles before AW
    wr_q.push_back('{a: 12'h305, d: 32'h12345678});
    b_q.push_back(3'd0);
    wdata  = 32'h12345678;
    wvalid = 1'b1;
    @(negedge clk);
    chk("t2_wready_pre", 64'(wready), 64'd1);
    step();
    wvalid = 1'b0;
    @(negedge clk);
    chk("t2_wready_held",  64'(wready),  64'd0);
    chk("t2_awready_open", 64'(awready), 64'd1);
    chk("t2_no_early_en",  64'(wr_en),   64'd0);
    step();
    step();
    awaddr  = 12'h305;
    awvalid = 1'b1;
    @(negedge clk);
    chk("t2_awready", 64'(awready), 64'd1);
    step();
    awvalid = 1'b0;
    @(negedge clk);
    chk("t2_wr_en", 64'(wr_en), 64'd1);
    wait_b();

    // Register file busy for four cycles in WRITE
    wr_q.push_back('{a: 12'h342, d: 32'hCAFEF00D});
    b_q.push_back(3'd0);
    wr_busy = 1'b1;
    awaddr  = 12'h342;
    wdata   = 32'hCAFEF00D;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_busy_no_en", 64'(wr_en), 64'd0);
      chk("t4_busy_no_b",  64'(bvalid), 64'd0);
      step();
    end
    wr_busy = 1'b0;
    @(negedge clk);
    chk("t4_en_after_busy", 64'(wr_en), 64'd1);
    step();
    @(negedge clk);
    chk("t4_bvalid", 64'(bvalid), 64'd1);
    chk("t4_en_once", 64'(wr_en), 64'd0);
    step();

    // bready held low: response must stay stable, channels closed
    bready = 1'b0;
    wr_q.push_back('{a: 12'h344, d: 32'hA5A5A5A5});
    b_q.push_back(3'd0);
    send(12'h344, 32'hA5A5A5A5);
    wait_bvalid();
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid_stable", 64'(bvalid),  64'd1);
      chk("t5_bresp_stable",  64'(bresp),   64'd0);
      chk("t5_awready_low",   64'(awready), 64'd0);
      chk("t5_wready_low",    64'(wready),  64'd0);
      step();
      @(negedge clk);
    end
    step();
    bready = 1'b1;
    @(negedge clk);
    chk("t5_bvalid_until_ready", 64'(bvalid), 64'd1);
    step();
    @(negedge clk);
    chk("t5_awready_back", 64'(awready), 64'd1);
    chk("t5_wready_back",  64'(wready),  64'd1);
    chk("t5_bvalid_done",  64'(bvalid),  64'd0);
    step();

    // Reset asserted while in RESP
    bready = 1'b0;
    wr_q.push_back('{a: 12'h300, d: 32'h00000011});
    send(12'h300, 32'h00000011);
    wait_bvalid();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_bvalid_async", 64'(bvalid),  64'd0);
    chk("t6_awready_rst",  64'(awready), 64'd0);
    chk("t6_wready_rst",   64'(wready),  64'd0);
    chk("t6_wr_en_rst",    64'(wr_en),   64'd0);
    step();
    step();
    reset_n = 1'b1;
    bready  = 1'b1;
    @(negedge clk);
    chk("t6_awready_idle", 64'(awready), 64'd1);
    chk("t6_wready_idle",  64'(wready),  64'd1);
    chk("t6_no_spurious",  64'(wr_en),   64'd0);
    chk("t6_bvalid_idle",  64'(bvalid),  64'd0);
`ifdef CSR_WRITE_ERR_COUNT_EN
    chk("t6_err_count_rst", 64'(err_count), 64'd0);
`endif
    step();
    step();
    step();
    wr_q.push_back('{a: 12'h341, d: 32'h00000077});
    b_q.push_back(3'd0);
    send(12'h341, 32'h00000077);
    wait_b();
    step();

    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    chk("b_queue_drained",  64'(b_q.size()),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
